// File: rtl/cp0_pkg.sv
// Shared CP0 constants: register indices, STATUS/CAUSE bit positions, ExcCodes, vector.
// Build option: define CP0_TIMER_EN to implement COUNT/COMPARE and the IP7 timer interrupt.
package cp0_pkg;

  localparam logic [4:0] REG_COUNT   = 5'd9;
  localparam logic [4:0] REG_COMPARE = 5'd11;
  localparam logic [4:0] REG_STATUS  = 5'd12;
  localparam logic [4:0] REG_CAUSE   = 5'd13;
  localparam logic [4:0] REG_EPC     = 5'd14;

  localparam int ST_IE     = 0;
  localparam int ST_EXL    = 1;
  localparam int ST_IM_LO  = 8;
  localparam int CA_EXC_LO = 2;
  localparam int CA_IP_LO  = 8;
  localparam int CA_IP7    = 15;

  // Only IE, EXL and IM exist in STATUS; everything else reads 0.
  localparam logic [31:0] STATUS_MASK = 32'h0000_ff03;

  typedef enum logic [4:0] {
    EXC_INT     = 5'd0,
    EXC_SYSCALL = 5'd8,
    EXC_BREAK   = 5'd9,
    EXC_TEQ     = 5'd13
  } exc_code_e;

  localparam logic [31:0] DEFAULT_VECTOR = 32'h0040_0004;

endpackage

// File: rtl/cp0_timer.sv
// COUNT/COMPARE timer: prescaled COUNT, COMPARE, and the sticky IP7 match latch.
// Only instantiated when CP0_TIMER_EN is defined.
module cp0_timer #(
  parameter int TIMER_DIV = 1
) (
  input  logic        in_clk,
  input  logic        in_rst,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        ip7
);

  localparam int PW = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;

  logic [PW-1:0] presc;
  logic          tick;
  logic [31:0]   count_inc;

  assign tick      = (presc == PW'(TIMER_DIV - 1));
  assign count_inc = count + 32'd1;

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      presc   <= '0;
      count   <= '0;
      compare <= '0;
      ip7     <= 1'b0;
    end else begin
      if (count_we) begin
        count <= wdata;
        presc <= '0;
      end else if (tick) begin
        count <= count_inc;
        presc <= '0;
      end else begin
        presc <= presc + 1'b1;
      end
      if (compare_we) compare <= wdata;
      // A COMPARE write acknowledges the interrupt even if a match lands on the same edge.
      if (compare_we)
        ip7 <= 1'b0;
      else if (!count_we && tick && count_inc == compare)
        ip7 <= 1'b1;
    end
  end

endmodule

// File: rtl/cp0_intc.sv
// MIPS coprocessor 0: STATUS/CAUSE/EPC, exceptions, ERET, synchronised external IRQs.
// Build option: define CP0_TIMER_EN to add COUNT/COMPARE and the IP7 timer interrupt.
module cp0_intc
  import cp0_pkg::*;
#(
  parameter int          NUM_IRQ    = 6,
  parameter logic [31:0] EXC_VECTOR = DEFAULT_VECTOR,
  parameter int          TIMER_DIV  = 1
) (
  input  logic               in_clk,
  input  logic               in_rst,
  input  logic               in_mfc0,
  input  logic               in_mtc0,
  input  logic [31:0]        in_pc,
  input  logic [4:0]         in_rdc,
  input  logic [31:0]        in_wdata,
  input  logic               in_exception,
  input  logic               in_eret,
  input  logic [4:0]         in_cause,
  input  logic [NUM_IRQ-1:0] in_irq,
  input  logic               in_stall,
  output logic [31:0]        out_rdata,
  output logic [31:0]        out_status,
  output logic [31:0]        out_eaddr,
  output logic               out_irq_take,
  output logic               out_timer_irq
);

  logic [1:0][NUM_IRQ-1:0] irq_sync;
  logic [31:0] status, epc, cause, count, compare, rd_reg;
  logic [4:0]  exc_code;
  logic [6:0]  ip_ext;
  logic        ip7, pend, wr_ok;

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) irq_sync <= '0;
    else        irq_sync <= {irq_sync[0], in_irq};
  end

  assign ip_ext = 7'(irq_sync[1]);
  assign cause  = {16'b0, ip7, ip_ext, 1'b0, exc_code, 2'b00};
  assign pend   = status[ST_IE] & ~status[ST_EXL]
                & |(cause[CA_IP7:CA_IP_LO] & status[ST_IM_LO+7:ST_IM_LO]);

  assign out_irq_take = pend & ~in_stall & ~in_exception & ~in_eret;
  assign wr_ok        = in_mtc0 & ~in_exception & ~out_irq_take & ~in_eret;

`ifdef CP0_TIMER_EN
  cp0_timer #(.TIMER_DIV(TIMER_DIV)) u_timer (
    .in_clk     (in_clk),
    .in_rst     (in_rst),
    .count_we   (wr_ok && in_rdc == REG_COUNT),
    .compare_we (wr_ok && in_rdc == REG_COMPARE),
    .wdata      (in_wdata),
    .count      (count),
    .compare    (compare),
    .ip7        (ip7)
  );
`else
  logic timer_div_unused;
  assign timer_div_unused = (TIMER_DIV > 256);
  assign count   = '0;
  assign compare = '0;
  assign ip7     = 1'b0;
`endif

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      status   <= '0;
      epc      <= '0;
      exc_code <= '0;
    end else if (in_exception) begin
      exc_code <= in_cause;
      // No nesting: a fault inside the handler keeps the original return address.
      if (!status[ST_EXL]) begin
        epc            <= in_pc;
        status[ST_EXL] <= 1'b1;
      end
    end else if (out_irq_take) begin
      epc            <= in_pc;
      exc_code       <= EXC_INT;
      status[ST_EXL] <= 1'b1;
    end else if (in_eret) begin
      status[ST_EXL] <= 1'b0;
    end else if (wr_ok) begin
      if (in_rdc == REG_STATUS) status <= in_wdata & STATUS_MASK;
      if (in_rdc == REG_EPC)    epc    <= in_wdata;
    end
  end

  always_comb begin
    rd_reg = '0;
    case (in_rdc)
      REG_COUNT:   rd_reg = count;
      REG_COMPARE: rd_reg = compare;
      REG_STATUS:  rd_reg = status;
      REG_CAUSE:   rd_reg = cause;
      REG_EPC:     rd_reg = epc;
      default:     rd_reg = '0;
    endcase
  end

  assign out_rdata     = in_mfc0 ? rd_reg : '0;
  assign out_status    = status;
  assign out_eaddr     = in_eret ? epc : EXC_VECTOR;
  assign out_timer_irq = ip7;

endmodule
